// File: rtl/btn_event_arbiter.sv
// btn_event_arbiter: turns debounced button levels into short/long press events on one valid/ready stream
module btn_event_arbiter #(
  parameter int N_BTN = 4,
  parameter int CLK_FREQ = 100_000_000,
  parameter int LONG_PRESS_MS = 1000,
  localparam int ID_W = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [N_BTN-1:0]  i_btn,
  output logic              o_evt_valid,
  input  logic              i_evt_ready,
  output logic [ID_W-1:0]   o_evt_id,
  output logic              o_evt_long,
  output logic [N_BTN-1:0]  o_overrun,
  input  logic              i_clr_overrun
);
  localparam int LONG_CYCLES = (CLK_FREQ / 1000) * LONG_PRESS_MS;
  localparam int CNT_W = $clog2(LONG_CYCLES + 1);
  typedef enum logic {IDLE, OFFER} state_t;
  state_t state;
  logic [N_BTN-1:0] armed, prev, long_sent, pending, ptype, post, gnt;
  logic [CNT_W-1:0] cnt [N_BTN];
  logic [ID_W-1:0] ptr, sel;
  logic found;
  always_comb begin
    post = '0;
    for (int b = 0; b < N_BTN; b++)
      post[b] = armed[b] & prev[b] & (i_btn[b] ? (cnt[b] == CNT_W'(LONG_CYCLES - 1)) : ~long_sent[b]);
  end
  // Scan downwards so the lowest offset from ptr is the one left standing.
  always_comb begin
    logic [ID_W-1:0] j;
    j = '0;
    sel = '0;
    found = 1'b0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      j = ID_W'((int'(ptr) + i) % N_BTN);
      if (pending[j]) begin
        sel = j;
        found = 1'b1;
      end
    end
    gnt = (state == IDLE && found) ? ({{(N_BTN-1){1'b0}}, 1'b1} << sel) : '0;
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      armed <= '0;
      prev <= '0;
      long_sent <= '0;
      pending <= '0;
      ptype <= '0;
      o_overrun <= '0;
      for (int b = 0; b < N_BTN; b++) cnt[b] <= '0;
    end else begin
      prev <= i_btn;
      armed <= armed | ~i_btn;
      pending <= post | (pending & ~gnt);
      o_overrun <= (o_overrun & {N_BTN{~i_clr_overrun}}) | (post & pending & ~gnt);
      for (int b = 0; b < N_BTN; b++) begin
        if (post[b] & (~pending[b] | gnt[b])) ptype[b] <= i_btn[b];
        if (armed[b]) begin
          if (i_btn[b] & ~prev[b]) begin
            cnt[b] <= CNT_W'(1);
            long_sent[b] <= 1'b0;
          end else if (i_btn[b]) begin
            if (cnt[b] != CNT_W'(LONG_CYCLES)) cnt[b] <= cnt[b] + CNT_W'(1);
            if (cnt[b] == CNT_W'(LONG_CYCLES - 1)) long_sent[b] <= 1'b1;
          end else if (prev[b]) begin
            cnt[b] <= '0;
          end
        end
      end
    end
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
      o_evt_valid <= 1'b0;
      o_evt_id <= '0;
      o_evt_long <= 1'b0;
      ptr <= '0;
    end else if (state == IDLE) begin
      if (found) begin
        o_evt_id <= sel;
        o_evt_long <= ptype[sel];
        o_evt_valid <= 1'b1;
        state <= OFFER;
      end
    end else if (i_evt_ready) begin
      o_evt_valid <= 1'b0;
      ptr <= (o_evt_id == ID_W'(N_BTN - 1)) ? '0 : o_evt_id + ID_W'(1);
      state <= IDLE;
    end
  end
endmodule
